// File: rtl/queue_fifo.sv
// Single-clock FIFO with a show-ahead read port: data_OUT is the current head entry.
// Optionally resets preloaded with DEPTH/2 .. DEPTH-1 (free-list use in rename).
module queue_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned SHOW_DEBUG = 0,
  parameter int unsigned INIT_CODE  = 0,
  parameter string       QUEUE_NAME = "QUEUE"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pushReq_IN,
  input  logic [DATA_WIDTH-1:0] data_IN,
  output logic                  fullFlag_OUT,
  input  logic                  popReq_IN,
  output logic [DATA_WIDTH-1:0] data_OUT,
  output logic                  emptyFlag_OUT,
  input  logic                  flush_IN
);

  localparam int unsigned Depth        = 2 ** ADDR_WIDTH;
  localparam int unsigned PreloadCount = (INIT_CODE != 0) ? Depth / 2 : 0;

  localparam logic [ADDR_WIDTH-1:0] TailRst  = ADDR_WIDTH'(PreloadCount);
  localparam logic [ADDR_WIDTH:0]   CountRst = (ADDR_WIDTH + 1)'(PreloadCount);
  localparam logic [ADDR_WIDTH:0]   CountMax = (ADDR_WIDTH + 1)'(Depth);

  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_rd [Depth];

  logic full, empty;
  logic push_acc, pop_acc, wr_en;

  assign full  = (count_q == CountMax);
  assign empty = (count_q == '0);

  // Acceptance is judged on the pre-edge state, so push+pop on an empty queue only pushes
  // and push+pop on a full queue only pops.
  assign push_acc = pushReq_IN && !full;
  assign pop_acc  = popReq_IN && !empty;
  assign wr_en    = push_acc && !flush_IN;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_IN) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_acc) begin
        tail_d = tail_q + 1'b1;
      end
      if (pop_acc) begin
        head_d = head_q + 1'b1;
      end
      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= TailRst;
      count_q <= CountRst;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Only the preloaded entries carry a reset; the rest are plain storage flops.
  for (genvar k = 0; k < Depth; k++) begin : g_mem
    logic [DATA_WIDTH-1:0] entry_q;
    logic                  entry_we;

    assign entry_we = wr_en && (tail_q == ADDR_WIDTH'(k));
    assign mem_rd[k] = entry_q;

    if (k < PreloadCount) begin : g_preload
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_q <= DATA_WIDTH'(PreloadCount + k);
        end else if (entry_we) begin
          entry_q <= data_IN;
        end
      end
    end else begin : g_plain
      always_ff @(posedge clk) begin
        if (entry_we) begin
          entry_q <= data_IN;
        end
      end
    end
  end

  assign data_OUT      = empty ? '0 : mem_rd[head_q];
  assign fullFlag_OUT  = full;
  assign emptyFlag_OUT = empty;

endmodule

// File: tb/tb_queue_fifo.sv
// Randomized and directed bench for queue_fifo; two instances (empty-reset and preloaded)
// are checked against queue-based reference models.
module tb_queue_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       push0 = 0, pop0 = 0, flush0 = 0;
  logic [7:0] din0 = '0, dout0;
  logic       full0, empty0;

  logic       push1 = 0, pop1 = 0, flush1 = 0;
  logic [5:0] din1 = '0, dout1;
  logic       full1, empty1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q0[$];
  logic [5:0] q1[$];

  always #5 clk = ~clk;

  queue_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .SHOW_DEBUG(0), .INIT_CODE(0), .QUEUE_NAME("Q0")
  ) dut0 (
    .clk(clk), .reset(rst_n), .pushReq_IN(push0), .data_IN(din0), .fullFlag_OUT(full0),
    .popReq_IN(pop0), .data_OUT(dout0), .emptyFlag_OUT(empty0), .flush_IN(flush0)
  );

  queue_fifo #(
    .DATA_WIDTH(6), .ADDR_WIDTH(6), .SHOW_DEBUG(0), .INIT_CODE(1), .QUEUE_NAME("Q1")
  ) dut1 (
    .clk(clk), .reset(rst_n), .pushReq_IN(push1), .data_IN(din1), .fullFlag_OUT(full1),
    .popReq_IN(pop1), .data_OUT(dout1), .emptyFlag_OUT(empty1), .flush_IN(flush1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic reset_models();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 32; k++) q1.push_back(6'(32 + k));
  endtask

  // Drive one cycle on dut0, compare against the model before the edge, then advance model.
  task automatic step0(input string tag, input bit push, input logic [7:0] d, input bit pop,
                       input bit flush);
    logic [7:0] exp_d;
    bit         was_full;
    push0 = push; din0 = d; pop0 = pop; flush0 = flush;
    @(negedge clk);
    exp_d = (q0.size() != 0) ? q0[0] : 8'h00;
    check({tag, ".empty"}, 32'(empty0), 32'(q0.size() == 0));
    check({tag, ".full"}, 32'(full0), 32'(q0.size() == 4));
    check({tag, ".data"}, 32'(dout0), 32'(exp_d));
    if (flush) begin
      q0.delete();
    end else begin
      was_full = (q0.size() == 4);
      if (pop && q0.size() != 0) void'(q0.pop_front());
      if (push && !was_full) q0.push_back(d);
    end
    @(posedge clk);
    #1;
    push0 = 0; pop0 = 0; flush0 = 0;
  endtask

  task automatic step1(input string tag, input bit push, input logic [5:0] d, input bit pop,
                       input bit flush);
    logic [5:0] exp_d;
    bit         was_full;
    push1 = push; din1 = d; pop1 = pop; flush1 = flush;
    @(negedge clk);
    exp_d = (q1.size() != 0) ? q1[0] : 6'h00;
    check({tag, ".empty"}, 32'(empty1), 32'(q1.size() == 0));
    check({tag, ".full"}, 32'(full1), 32'(q1.size() == 64));
    check({tag, ".data"}, 32'(dout1), 32'(exp_d));
    if (flush) begin
      q1.delete();
    end else begin
      was_full = (q1.size() == 64);
      if (pop && q1.size() != 0) void'(q1.pop_front());
      if (push && !was_full) q1.push_back(d);
    end
    @(posedge clk);
    #1;
    push1 = 0; pop1 = 0; flush1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq;
    reset_models();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Out of reset, popping an empty queue changes nothing.
    check("rst0.empty", 32'(empty0), 32'd1);
    check("rst0.full", 32'(full0), 32'd0);
    check("rst0.data", 32'(dout0), 32'd0);
    step0("pop_empty", 0, 8'h00, 1, 0);
    step0("pop_empty2", 0, 8'h00, 0, 0);

    // Fill, overflow, drain.
    step0("fill1", 1, 8'h11, 0, 0);
    step0("fill2", 1, 8'h22, 0, 0);
    step0("fill3", 1, 8'h33, 0, 0);
    step0("fill4", 1, 8'h44, 0, 0);
    check("full_after4", 32'(full0), 32'd1);
    step0("drop55", 1, 8'h55, 0, 0);
    check("head_after_drop", 32'(dout0), 32'h11);
    for (int i = 0; i < 4; i++) step0("drain", 0, 8'h00, 1, 0);
    check("empty_after_drain", 32'(empty0), 32'd1);

    // Pointer wrap: push two, pop two, strictly sequential data.
    seq = 8'h60;
    for (int r = 0; r < 5; r++) begin
      step0("wrap_push", 1, seq, 0, 0);
      step0("wrap_push", 1, seq + 8'd1, 0, 0);
      check("wrap_head", 32'(dout0), 32'(seq));
      step0("wrap_pop", 0, 8'h00, 1, 0);
      check("wrap_head2", 32'(dout0), 32'(seq + 8'd1));
      step0("wrap_pop", 0, 8'h00, 1, 0);
      seq = seq + 8'd2;
    end

    // Full with push+pop: only the pop happens.
    for (int i = 0; i < 4; i++) step0("refill", 1, 8'(8'hA0 + i), 0, 0);
    step0("full_pushpop", 1, 8'hEE, 1, 0);
    check("full_pp.full", 32'(full0), 32'd0);
    check("full_pp.head", 32'(dout0), 32'hA1);
    step0("flush", 0, 8'h00, 0, 1);
    // Empty with push+pop: only the push happens, visible next cycle.
    step0("empty_pushpop", 1, 8'h7C, 1, 0);
    check("empty_pp.data", 32'(dout0), 32'h7C);
    step0("after_epp", 0, 8'h00, 0, 0);

    // Flush with three entries overrides a concurrent push.
    step0("f3a", 1, 8'h01, 0, 0);
    step0("f3b", 1, 8'h02, 0, 0);
    step0("f3c", 1, 8'h03, 0, 0);
    step0("flush_push", 1, 8'h04, 0, 1);
    check("flush.empty", 32'(empty0), 32'd1);
    check("flush.data", 32'(dout0), 32'd0);

    // Randomized traffic on dut0.
    for (int i = 0; i < 400; i++) begin
      step0("rand0", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset mid-stream, between clock edges.
    step0("pre_rst", 1, 8'h5A, 0, 0);
    step1("pre_rst1", 0, 6'h00, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.empty0", 32'(empty0), 32'd1);
    check("async.data0", 32'(dout0), 32'd0);
    check("async.empty1", 32'(empty1), 32'd0);
    check("async.data1", 32'(dout1), 32'd32);
    reset_models();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preloaded instance: 32..63 then empty, then a push shows up next cycle.
    check("pre.full", 32'(full1), 32'd0);
    for (int i = 0; i < 32; i++) step1("preload_pop", 0, 6'h00, 1, 0);
    check("pre.empty_end", 32'(empty1), 32'd1);
    step1("push5", 1, 6'd5, 0, 0);
    check("push5.data", 32'(dout1), 32'd5);
    step1("after5", 0, 6'h00, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step1("rand1", ($urandom_range(0, 2) != 0), 6'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
